dac_mix_ctrl: RTL and testbench

Sequences the shared 8-bit delta-sigma DAC input for the audio path. Two sound sources hand samples over through valid/ready handshakes. The block paces them at a fixed sample tick, mixes them with a halving sum, and drives the DAC code. A mute state machine ramps the code between 0x00 (power-on level) and midscale 0x80 to suppress pops at enable and disable.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/dac_src_buf.sv | 58 +++++
 rtl/dac_mix_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dac_mix_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio DAC path: mute/ramp state encoding,
// the DAC midscale level and the two-source halving mixer.
package audio_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'b00,
        RAMP_UP   = 2'b01,
        RUN       = 2'b10,
        RAMP_DOWN = 2'b11
    } state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;

    // Offset-binary in, offset-binary out: ((a-128)+(b-128))>>>1 re-biased by 128.
    function automatic logic [7:0] mix8(input logic [7:0] a, input logic [7:0] b);
        logic signed [9:0] m;
        logic signed [9:0] s;
        m = $signed({2'b00, a}) + $signed({2'b00, b}) - 10'sd256;
        s = m >>> 1;
        return s[7:0] + MIDSCALE;
    endfunction

endpackage

// File: rtl/dac_src_buf.sv
// One-entry sample buffer plus hold register for a single audio source.
// Ports:
//   clk_i, res_i      clock, asynchronous active-high reset
//   tick_i            sample strobe; moves a buffered sample into the hold register
//   run_i             mixer is in RUN; an empty buffer at a tick is an underrun
//   clr_i             clears the sticky underrun flag
//   data_i, valid_i   source handshake input
//   ready_o           buffer can take a sample this cycle
//   hold_o            sample currently presented to the mixer
//   underrun_o        sticky underrun flag
module dac_src_buf
    import audio_pkg::*;
(
    input  logic       clk_i,
    input  logic       res_i,
    input  logic       tick_i,
    input  logic       run_i,
    input  logic       clr_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] hold_o,
    output logic       underrun_o
);

    logic       full;
    logic [7:0] buf_q;
    logic       accept;

    // On a tick the entry drains into hold, so a new sample can enter even when full.
    assign ready_o = ~full | tick_i;
    assign accept  = valid_i & ready_o;

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            full       <= 1'b0;
            buf_q      <= '0;
            hold_o     <= MIDSCALE;
            underrun_o <= 1'b0;
        end else begin
            if (clr_i)
                underrun_o <= 1'b0;
            if (tick_i) begin
                if (full)
                    hold_o <= buf_q;
                else if (run_i)
                    underrun_o <= 1'b1;
            end
            if (accept) begin
                buf_q <= data_i;
                full  <= 1'b1;
            end else if (tick_i) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dac_mix_ctrl.sv
// DAC input sequencer: paces two sources at a fixed sample tick, mixes them
// with a halving sum and ramps the DAC code between 0x00 and midscale on
// enable/disable to avoid pops.
// Ports:
//   clk_i, res_i                  clock, asynchronous active-high reset
//   en_i                          1 = unmute, 0 = mute (sampled on ticks only)
//   srcN_data_i/valid_i/ready_o   source N sample handshake
//   dac_o                         registered DAC code
//   tick_o                        one-cycle sample strobe, period TICK_DIV
//   state_o                       MUTED / RAMP_UP / RUN / RAMP_DOWN
//   underrun_o                    sticky per-source underrun flags
module dac_mix_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned TICK_DIV = 64,
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic       clk_i,
    input  logic       res_i,
    input  logic       en_i,
    input  logic [7:0] src0_data_i,
    input  logic       src0_valid_i,
    output logic       src0_ready_o,
    input  logic [7:0] src1_data_i,
    input  logic       src1_valid_i,
    output logic       src1_ready_o,
    output logic [7:0] dac_o,
    output logic       tick_o,
    output logic [1:0] state_o,
    output logic [1:0] underrun_o
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [RW-1:0] ramp_cnt;
    logic          tick_d;
    logic          en_s;
    logic [7:0]    hold0;
    logic [7:0]    hold1;
    logic [7:0]    mix;
    logic [7:0]    dac_toward;
    logic          ramp_step;
    logic          clr_ur;
    logic          run;

    assign state_o   = state;
    assign run       = (state == RUN);
    assign mix       = mix8(hold0, hold1);
    assign ramp_step = (ramp_cnt == RAMP_LAST);
    // RAMP_UP reaching midscale on a step is the only way into RUN.
    assign clr_ur    = tick_d & (state == RAMP_UP) & en_s & ramp_step & (dac_o == MIDSCALE);

    always_comb begin
        dac_toward = dac_o;
        if (dac_o < MIDSCALE)
            dac_toward = dac_o + 8'd1;
        else if (dac_o > MIDSCALE)
            dac_toward = dac_o - 8'd1;
    end

    // tick_o is registered from the count one ahead so it is high exactly while count==TICK_DIV-1.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            tick_cnt <= '0;
            tick_o   <= 1'b0;
            tick_d   <= 1'b0;
            en_s     <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            tick_o   <= (tick_cnt == TICK_PRE);
            tick_d   <= tick_o;
            if (tick_o)
                en_s <= en_i;
        end
    end

    dac_src_buf u_src0 (
        .clk_i      (clk_i),
        .res_i      (res_i),
        .tick_i     (tick_o),
        .run_i      (run),
        .clr_i      (clr_ur),
        .data_i     (src0_data_i),
        .valid_i    (src0_valid_i),
        .ready_o    (src0_ready_o),
        .hold_o     (hold0),
        .underrun_o (underrun_o[0])
    );

    dac_src_buf u_src1 (
        .clk_i      (clk_i),
        .res_i      (res_i),
        .tick_i     (tick_o),
        .run_i      (run),
        .clr_i      (clr_ur),
        .data_i     (src1_data_i),
        .valid_i    (src1_valid_i),
        .ready_o    (src1_ready_o),
        .hold_o     (hold1),
        .underrun_o (underrun_o[1])
    );

    // Entering a ramp from MUTED, RUN or the opposite ramp takes its first
    // step on the transition tick; only RAMP_UP -> RAMP_DOWN holds the level.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state    <= MUTED;
            dac_o    <= '0;
            ramp_cnt <= '0;
        end else if (tick_d) begin
            unique case (state)
                MUTED: begin
                    ramp_cnt <= '0;
                    dac_o    <= '0;
                    if (en_s) begin
                        state <= RAMP_UP;
                        dac_o <= dac_toward;
                    end
                end
                RAMP_UP: begin
                    if (!en_s) begin
                        state    <= RAMP_DOWN;
                        ramp_cnt <= '0;
                    end else if (ramp_step) begin
                        ramp_cnt <= '0;
                        if (dac_o == MIDSCALE)
                            state <= RUN;
                        else
                            dac_o <= dac_toward;
                    end else begin
                        ramp_cnt <= ramp_cnt + RW'(1);
                    end
                end
                RUN: begin
                    ramp_cnt <= '0;
                    if (!en_s) begin
                        state <= RAMP_DOWN;
                        if (dac_o != '0)
                            dac_o <= dac_o - 8'd1;
                    end else begin
                        dac_o <= mix;
                    end
                end
                RAMP_DOWN: begin
                    if (en_s) begin
                        state    <= RAMP_UP;
                        ramp_cnt <= '0;
                        dac_o    <= dac_toward;
                    end else if (ramp_step) begin
                        ramp_cnt <= '0;
                        if (dac_o == '0)
                            state <= MUTED;
                        else
                            dac_o <= dac_o - 8'd1;
                    end else begin
                        ramp_cnt <= ramp_cnt + RW'(1);
                    end
                end
                default: state <= MUTED;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_mix_ctrl.sv
module tb_dac_mix_ctrl;

    logic       clk_i = 1'b0;
    logic       res_i;
    logic       en_i;
    logic [7:0] src0_data_i;
    logic       src0_valid_i;
    logic       src0_ready_o;
    logic [7:0] src1_data_i;
    logic       src1_valid_i;
    logic       src1_ready_o;
    logic [7:0] dac_o;
    logic       tick_o;
    logic [1:0] state_o;
    logic [1:0] underrun_o;

    int checks = 0;
    int passed = 0;

    // Reference model: per-tick view of the sources and the output level.
    // m_state: 0 muted, 1 ramping up, 2 running, 3 ramping down.
    int         m_state;
    int         m_dac;
    int         m_hold [2];
    int         m_buf  [2];
    bit         m_full [2];
    logic [1:0] m_ur;

    always #5 clk_i = ~clk_i;

    dac_mix_ctrl #(.TICK_DIV(4), .RAMP_DIV(1)) dut (
        .clk_i        (clk_i),
        .res_i        (res_i),
        .en_i         (en_i),
        .src0_data_i  (src0_data_i),
        .src0_valid_i (src0_valid_i),
        .src0_ready_o (src0_ready_o),
        .src1_data_i  (src1_data_i),
        .src1_valid_i (src1_valid_i),
        .src1_ready_o (src1_ready_o),
        .dac_o        (dac_o),
        .tick_o       (tick_o),
        .state_o      (state_o),
        .underrun_o   (underrun_o)
    );

    task automatic model_reset;
        m_state = 0;
        m_dac   = 0;
        m_ur    = 2'b00;
        for (int s = 0; s < 2; s++) begin
            m_hold[s] = 128;
            m_buf[s]  = 0;
            m_full[s] = 0;
        end
    endtask

    task automatic model_tick(input logic en);
        for (int s = 0; s < 2; s++) begin
            if (m_full[s]) begin
                m_hold[s] = m_buf[s];
                m_full[s] = 0;
            end else if (m_state == 2) begin
                m_ur[s] = 1'b1;
            end
        end
        case (m_state)
            0: if (en) begin m_state = 1; m_dac = 1; end
            1: begin
                if (!en) m_state = 3;
                else if (m_dac == 128) begin m_state = 2; m_ur = 2'b00; end
                else m_dac = (m_dac < 128) ? m_dac + 1 : m_dac - 1;
            end
            2: begin
                if (!en) begin
                    m_state = 3;
                    if (m_dac > 0) m_dac = m_dac - 1;
                end else begin
                    m_dac = (m_hold[0] + m_hold[1]) / 2;
                end
            end
            default: begin
                if (en) begin
                    m_state = 1;
                    if (m_dac < 128) m_dac = m_dac + 1;
                    else if (m_dac > 128) m_dac = m_dac - 1;
                end else if (m_dac == 0) m_state = 0;
                else m_dac = m_dac - 1;
            end
        endcase
    endtask

    task automatic wait_tick;
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!tick_o && n < 50);
        if (!tick_o) begin
            checks++;
            $display("FAIL tick_timeout: tick_o=%b required 1 within 50 cycles", tick_o);
        end
    endtask

    // One sample period: sample en on the tick, offer new samples the cycle
    // after, return two cycles after the tick when dac_o has updated.
    task automatic run_period(input logic en, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1);
        wait_tick();
        en_i = en;
        model_tick(en);
        @(negedge clk_i);
        src0_valid_i = v0 && !m_full[0];
        src0_data_i  = d0;
        src1_valid_i = v1 && !m_full[1];
        src1_data_i  = d1;
        if (src0_valid_i) begin m_buf[0] = d0; m_full[0] = 1; end
        if (src1_valid_i) begin m_buf[1] = d1; m_full[1] = 1; end
        @(negedge clk_i);
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        res_i = 1'b1; en_i = 1'b0;
        src0_valid_i = 1'b0; src0_data_i = '0;
        src1_valid_i = 1'b0; src1_data_i = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        checks++; if (dac_o !== 8'h00) $display("FAIL reset_dac: got %h required 00", dac_o); else passed++;
        checks++; if (tick_o !== 1'b0) $display("FAIL reset_tick: got %b required 0", tick_o); else passed++;
        checks++; if (state_o !== 2'b00) $display("FAIL reset_state: got %b required 00", state_o); else passed++;
        checks++; if (underrun_o !== 2'b00) $display("FAIL reset_underrun: got %b required 00", underrun_o); else passed++;
        checks++; if ({src0_ready_o, src1_ready_o} !== 2'b11) $display("FAIL reset_ready: got %b required 11", {src0_ready_o, src1_ready_o}); else passed++;
        res_i = 1'b0;
    endtask

    task automatic test_tick;
        int n;
        wait_tick();
        model_tick(1'b0);
        @(negedge clk_i);
        checks++; if (tick_o !== 1'b0) $display("FAIL tick_width: got %b required 0", tick_o); else passed++;
        n = 1;
        while (!tick_o && n < 20) begin @(negedge clk_i); n++; end
        model_tick(1'b0);
        checks++; if (n !== 4) $display("FAIL tick_period: got %0d required 4", n); else passed++;
        checks++; if (state_o !== 2'b00) $display("FAIL tick_muted: got %b required 00", state_o); else passed++;
    endtask

    task automatic test_ramp_up;
        for (int i = 1; i <= 129; i++) begin
            run_period(1'b1, 1'b1, 8'h80, 1'b1, 8'h80);
            if (i <= 128) begin
                checks++; if (dac_o !== 8'(i)) $display("FAIL ramp_up_dac[%0d]: got %h required %h", i, dac_o, 8'(i)); else passed++;
                checks++; if (state_o !== 2'b01) $display("FAIL ramp_up_state[%0d]: got %b required 01", i, state_o); else passed++;
            end else begin
                checks++; if (dac_o !== 8'h80) $display("FAIL ramp_up_top: got %h required 80", dac_o); else passed++;
                checks++; if (state_o !== 2'b10) $display("FAIL ramp_up_run: got %b required 10", state_o); else passed++;
            end
        end
    endtask

    task automatic test_mix;
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic [7:0] e [4];
        logic [7:0] r0, r1;
        a = '{8'hC0, 8'hFF, 8'h00, 8'h00};
        b = '{8'h80, 8'hFF, 8'h00, 8'hFF};
        e = '{8'hA0, 8'hFF, 8'h00, 8'h7F};
        for (int k = 0; k < 4; k++) begin
            run_period(1'b1, 1'b1, a[k], 1'b1, b[k]);
            run_period(1'b1, 1'b1, a[k], 1'b1, b[k]);
            checks++; if (dac_o !== e[k]) $display("FAIL mix_fixed[%0d]: got %h required %h", k, dac_o, e[k]); else passed++;
        end
        for (int k = 0; k < 24; k++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            run_period(1'b1, 1'b1, r0, 1'b1, r1);
            checks++; if (dac_o !== 8'(m_dac)) $display("FAIL mix_random[%0d]: got %h required %h", k, dac_o, 8'(m_dac)); else passed++;
        end
        checks++; if (underrun_o !== 2'b00) $display("FAIL mix_no_underrun: got %b required 00", underrun_o); else passed++;
    endtask

    task automatic test_back_to_back;
        run_period(1'b1, 1'b1, 8'h20, 1'b1, 8'h80);
        checks++; if (src0_ready_o !== 1'b0) $display("FAIL b2b_full_ready: got %b required 0", src0_ready_o); else passed++;
        wait_tick();
        en_i = 1'b1;
        model_tick(1'b1);
        checks++; if (src0_ready_o !== 1'b1) $display("FAIL b2b_tick_ready: got %b required 1", src0_ready_o); else passed++;
        src0_valid_i = 1'b1; src0_data_i = 8'hE0;
        src1_valid_i = 1'b1; src1_data_i = 8'h80;
        m_buf[0] = 8'hE0; m_full[0] = 1;
        m_buf[1] = 8'h80; m_full[1] = 1;
        @(negedge clk_i);
        src0_valid_i = 1'b0; src1_valid_i = 1'b0;
        checks++; if (src0_ready_o !== 1'b0) $display("FAIL b2b_kept_full: got %b required 0", src0_ready_o); else passed++;
        @(negedge clk_i);
        checks++; if (dac_o !== 8'h50) $display("FAIL b2b_old_sample: got %h required 50", dac_o); else passed++;
        run_period(1'b1, 1'b1, 8'h80, 1'b1, 8'h80);
        checks++; if (dac_o !== 8'hB0) $display("FAIL b2b_new_sample: got %h required b0", dac_o); else passed++;
        run_period(1'b1, 1'b1, 8'h80, 1'b1, 8'h80);
        checks++; if (dac_o !== 8'h80) $display("FAIL b2b_after: got %h required 80", dac_o); else passed++;
        checks++; if (underrun_o !== m_ur) $display("FAIL b2b_underrun: got %b required %b", underrun_o, m_ur); else passed++;
    endtask

    task automatic test_underrun;
        run_period(1'b1, 1'b1, 8'h80, 1'b1, 8'h90);
        run_period(1'b1, 1'b1, 8'h80, 1'b0, 8'h00);
        checks++; if (dac_o !== 8'h88) $display("FAIL ur_first: got %h required 88", dac_o); else passed++;
        checks++; if (underrun_o !== 2'b00) $display("FAIL ur_none_yet: got %b required 00", underrun_o); else passed++;
        for (int k = 0; k < 3; k++) begin
            run_period(1'b1, 1'b1, 8'h80, 1'b0, 8'h00);
            checks++; if (dac_o !== 8'h88) $display("FAIL ur_hold[%0d]: got %h required 88", k, dac_o); else passed++;
            checks++; if (underrun_o !== 2'b10) $display("FAIL ur_flag[%0d]: got %b required 10", k, underrun_o); else passed++;
        end
    endtask

    task automatic test_ramp_down_up;
        int k;
        run_period(1'b1, 1'b1, 8'hC0, 1'b1, 8'h80);
        run_period(1'b1, 1'b1, 8'hC0, 1'b1, 8'h80);
        checks++; if (dac_o !== 8'hA0) $display("FAIL rd_start: got %h required a0", dac_o); else passed++;
        k = 0;
        while (m_dac != 8'h50 && k < 200) begin
            k++;
            run_period(1'b0, 1'b1, 8'h80, 1'b1, 8'h80);
            checks++; if (dac_o !== 8'(8'hA0 - k)) $display("FAIL rd_dac[%0d]: got %h required %h", k, dac_o, 8'(8'hA0 - k)); else passed++;
            checks++; if (state_o !== 2'b11) $display("FAIL rd_state[%0d]: got %b required 11", k, state_o); else passed++;
            checks++; if (underrun_o !== 2'b10) $display("FAIL rd_ur_sticky[%0d]: got %b required 10", k, underrun_o); else passed++;
        end
        k = 0;
        while (m_state != 2 && k < 200) begin
            k++;
            run_period(1'b1, 1'b1, 8'h80, 1'b1, 8'h80);
            checks++; if (dac_o !== 8'(m_dac)) $display("FAIL ru_dac[%0d]: got %h required %h", k, dac_o, 8'(m_dac)); else passed++;
            if (k <= 48) begin
                checks++; if (dac_o !== 8'(8'h50 + k)) $display("FAIL ru_step[%0d]: got %h required %h", k, dac_o, 8'(8'h50 + k)); else passed++;
            end
        end
        checks++; if (k !== 49) $display("FAIL ru_len: got %0d required 49", k); else passed++;
        checks++; if (state_o !== 2'b10) $display("FAIL ru_run: got %b required 10", state_o); else passed++;
        checks++; if (underrun_o !== 2'b00) $display("FAIL ru_ur_clear: got %b required 00", underrun_o); else passed++;
    endtask

    task automatic test_async_reset;
        int k;
        k = 0;
        while (m_dac != 8'h40 && k < 200) begin
            k++;
            run_period(1'b0, 1'b1, 8'h80, 1'b1, 8'h80);
        end
        checks++; if (dac_o !== 8'h40) $display("FAIL ar_level: got %h required 40", dac_o); else passed++;
        #2;
        res_i = 1'b1;
        src0_valid_i = 1'b1; src0_data_i = 8'h11;
        src1_valid_i = 1'b1; src1_data_i = 8'h22;
        #1;
        checks++; if (dac_o !== 8'h00) $display("FAIL ar_dac: got %h required 00", dac_o); else passed++;
        checks++; if (state_o !== 2'b00) $display("FAIL ar_state: got %b required 00", state_o); else passed++;
        checks++; if (tick_o !== 1'b0) $display("FAIL ar_tick: got %b required 0", tick_o); else passed++;
        repeat (3) @(negedge clk_i);
        src0_valid_i = 1'b0; src1_valid_i = 1'b0;
        en_i = 1'b1;
        res_i = 1'b0;
        model_reset();
        #1;
        checks++; if ({src0_ready_o, src1_ready_o} !== 2'b11) $display("FAIL ar_no_accept: got %b required 11", {src0_ready_o, src1_ready_o}); else passed++;
        for (int i = 1; i <= 3; i++) begin
            run_period(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
            checks++; if (dac_o !== 8'(i)) $display("FAIL ar_restart[%0d]: got %h required %h", i, dac_o, 8'(i)); else passed++;
            checks++; if (state_o !== 2'b01) $display("FAIL ar_restart_state[%0d]: got %b required 01", i, state_o); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_ramp_up();
        test_mix();
        test_back_to_back();
        test_underrun();
        test_ramp_down_up();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
